// File: rtl/withdraw_pkg.sv
// Shared types and helpers for the cash-withdrawal controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package withdraw_pkg;

   // Controller states; the encoding is visible on state_dbg.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_CHECK    = 3'd2,
      ST_DISPENSE = 3'd3,
      ST_DONE     = 3'd4,
      ST_DENY     = 3'd5
   } state_t;

   // Amount code to number of bills: 00->1 ... 11->4.
   function automatic logic [2:0] sel_to_amt(input logic [1:0] sel_code);
      return {1'b0, sel_code} + 3'd1;
   endfunction

endpackage

// File: rtl/gap_timer.sv
// Bill pacing counter: ticks on the first cycle of run, then every BILL_GAP cycles.
// Latency: tick is combinational from run and the registered count (no extra delay).
// Backpressure: none; dropping run restarts the phase.
module gap_timer
   import withdraw_pkg::*;
#(
   parameter int BILL_GAP = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int CW = (BILL_GAP > 1) ? $clog2(BILL_GAP) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count modulo BILL_GAP while running, hold at zero otherwise.
   always_comb begin
      cnt_d = '0;
      if (run) begin
         if (cnt_q == CW'(BILL_GAP - 1)) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = run & (cnt_q == '0);

endmodule

// File: rtl/withdraw_ctrl.sv
// Cash-withdrawal session controller: select, funds check, paced bill dispense.
// Latency: confirm -> CHECK next edge; first bill one cycle after CHECK.
// Backpressure: none; start/confirm/cancel are only honoured in their owning state.
module withdraw_ctrl
   import withdraw_pkg::*;
#(
   parameter int BAL_W          = 8,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int BILL_GAP       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       sel,
   input  logic             confirm,
   input  logic             cancel,
   input  logic             load_bal,
   input  logic [BAL_W-1:0] bal_in,
   output logic [BAL_W-1:0] balance,
   output logic             busy,
   output logic             bill_pulse,
   output logic             ok,
   output logic             nomoney,
   output logic             timeout,
   output logic [2:0]       state_dbg
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state_q, state_d;
   logic [BAL_W-1:0] bal_q, bal_d;
   logic [2:0]       amt_q, amt_d;
   logic [2:0]       bills_q, bills_d;
   logic [TW-1:0]    tmo_q, tmo_d;

   logic             dispensing;
   logic             tick;
   logic             tmo_expired;
   logic             funds_ok;

   assign dispensing  = (state_q == ST_DISPENSE);
   // Expiry is visible in the SELECT cycle after TIMEOUT_CYCLES idle cycles.
   assign tmo_expired = (state_q == ST_SELECT) && (tmo_q == TW'(TIMEOUT_CYCLES));
   assign funds_ok    = (bal_q >= BAL_W'(amt_q));

   gap_timer #(
      .BILL_GAP (BILL_GAP)
   ) u_gap_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (dispensing),
      .tick  (tick)
   );

   // Next-state, balance, amount and counter updates.
   always_comb begin
      state_d = state_q;
      bal_d   = bal_q;
      amt_d   = amt_q;
      bills_d = bills_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (load_bal) begin
               bal_d = bal_in;
            end
            if (start) begin
               state_d = ST_SELECT;
               tmo_d   = '0;
            end
         end
         ST_SELECT: begin
            // cancel beats confirm, confirm beats an expiring timeout
            if (cancel) begin
               state_d = ST_IDLE;
            end else if (confirm) begin
               amt_d   = sel_to_amt(sel);
               state_d = ST_CHECK;
            end else if (tmo_expired) begin
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_CHECK: begin
            bills_d = '0;
            if (funds_ok) begin
               bal_d   = bal_q - BAL_W'(amt_q);
               state_d = ST_DISPENSE;
            end else begin
               state_d = ST_DENY;
            end
         end
         ST_DISPENSE: begin
            if (tick) begin
               bills_d = bills_q + 3'd1;
               if ((bills_q + 3'd1) == amt_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_DENY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         bal_q   <= '0;
         amt_q   <= '0;
         bills_q <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         bal_q   <= bal_d;
         amt_q   <= amt_d;
         bills_q <= bills_d;
         tmo_q   <= tmo_d;
      end
   end

   // Moore outputs: all decoded from registered state and counters.
   assign balance    = bal_q;
   assign busy       = (state_q != ST_IDLE);
   assign bill_pulse = tick;
   assign ok         = (state_q == ST_DONE);
   assign nomoney    = (state_q == ST_DENY);
   assign timeout    = tmo_expired;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_withdraw_ctrl.sv
// Self-checking bench for withdraw_ctrl: directed scenarios plus random sessions.
// Latency: n/a.
// Backpressure: n/a.
module tb_withdraw_ctrl;

   localparam int BAL_W = 8;
   localparam int TMO   = 8;
   localparam int GAP   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       sel = 2'd0;
   logic             confirm = 1'b0;
   logic             cancel = 1'b0;
   logic             load_bal = 1'b0;
   logic [BAL_W-1:0] bal_in = '0;
   logic [BAL_W-1:0] balance;
   logic             busy;
   logic             bill_pulse;
   logic             ok;
   logic             nomoney;
   logic             timeout;
   logic [2:0]       state_dbg;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int excl_bad = 0;
   int pulse_q[$];
   int ok_q[$];
   int nom_q[$];
   int tmo_q[$];

   withdraw_ctrl #(
      .BAL_W          (BAL_W),
      .TIMEOUT_CYCLES (TMO),
      .BILL_GAP       (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .sel        (sel),
      .confirm    (confirm),
      .cancel     (cancel),
      .load_bal   (load_bal),
      .bal_in     (bal_in),
      .balance    (balance),
      .busy       (busy),
      .bill_pulse (bill_pulse),
      .ok         (ok),
      .nomoney    (nomoney),
      .timeout    (timeout),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen mid-cycle equals the number of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder on the falling edge.
   always @(negedge clk) begin
      if (bill_pulse) pulse_q.push_back(cyc);
      if (ok)         ok_q.push_back(cyc);
      if (nomoney)    nom_q.push_back(cyc);
      if (timeout)    tmo_q.push_back(cyc);
      if ((int'(bill_pulse) + int'(ok) + int'(nomoney) + int'(timeout)) > 1) excl_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int i;
      i = 0;
      while (busy && i < 200) begin
         step();
         i++;
      end
      chk(tag, busy, 0);
   endtask

   // One full session with a reference prediction of bills, timing, outcome and balance.
   task automatic session(input int bal, input logic [1:0] s, input int dly, input bit poke_load);
      int pb, ob, nb, tb0, pc, amt, exp_bal;
      bit pays;
      pb  = pulse_q.size();
      ob  = ok_q.size();
      nb  = nom_q.size();
      tb0 = tmo_q.size();
      load_bal = 1'b1; bal_in = BAL_W'(bal); start = 1'b1;
      step();
      load_bal = 1'b0; start = 1'b0;
      chk("sess_load_bal", balance, bal);
      chk("sess_select", state_dbg, 1);
      repeat (dly) step();
      sel = s; confirm = 1'b1;
      step();
      confirm = 1'b0;
      pc = cyc;
      chk("sess_check", state_dbg, 2);
      amt     = int'(s) + 1;
      pays    = (bal >= amt);
      exp_bal = pays ? bal - amt : bal;
      if (poke_load) begin
         step();
         load_bal = 1'b1; bal_in = BAL_W'($urandom);
         step();
         load_bal = 1'b0;
      end
      wait_idle("sess_idle");
      chk("sess_pulses", pulse_q.size() - pb, pays ? amt : 0);
      if (pays) begin
         for (int i = 0; i < amt; i++) begin
            if (pb + i < pulse_q.size()) chk("sess_pulse_time", pulse_q[pb + i], pc + 1 + GAP * i);
         end
         chk("sess_ok_cnt", ok_q.size() - ob, 1);
         if (ok_q.size() > ob) chk("sess_ok_time", ok_q[ob], pc + 2 + GAP * (amt - 1));
         chk("sess_nom_cnt", nom_q.size() - nb, 0);
      end else begin
         chk("sess_nom_cnt", nom_q.size() - nb, 1);
         if (nom_q.size() > nb) chk("sess_nom_time", nom_q[nb], pc + 1);
         chk("sess_ok_cnt", ok_q.size() - ob, 0);
      end
      chk("sess_tmo_cnt", tmo_q.size() - tb0, 0);
      chk("sess_balance", balance, exp_bal);
   endtask

   initial begin
      int pb, ob, nb, tb0, ps, pc, i;

      // Reset values
      #12;
      chk("rst_balance", balance, 0);
      chk("rst_state", state_dbg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_outs", {bill_pulse, ok, nomoney, timeout}, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rel_state", state_dbg, 0);
      chk("rel_busy", busy, 0);

      // Two bills from a balance of five
      session(5, 2'b01, 0, 1'b0);
      // Denied: four bills from a balance of two
      session(2, 2'b11, 1, 1'b0);
      // load_bal during dispensing is ignored
      session(9, 2'b10, 2, 1'b1);

      // Session expiry with no input
      tb0 = tmo_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      ps = cyc;
      chk("tmo_select", state_dbg, 1);
      repeat (TMO) step();
      chk("tmo_pulse", timeout, 1);
      chk("tmo_busy_hi", busy, 1);
      step();
      chk("tmo_busy_lo", busy, 0);
      chk("tmo_pulse_end", timeout, 0);
      chk("tmo_cnt", tmo_q.size() - tb0, 1);
      if (tmo_q.size() > tb0) chk("tmo_time", tmo_q[tb0], ps + TMO);

      // Confirm arriving on the expiry cycle proceeds with the withdrawal
      ob = ok_q.size();
      load_bal = 1'b1; bal_in = 8'd6; start = 1'b1;
      step();
      load_bal = 1'b0; start = 1'b0;
      repeat (TMO) step();
      sel = 2'b00; confirm = 1'b1;
      step();
      confirm = 1'b0;
      chk("late_conf_check", state_dbg, 2);
      wait_idle("late_conf_idle");
      chk("late_conf_ok", ok_q.size() - ob, 1);
      chk("late_conf_bal", balance, 5);

      // Confirm and cancel together: cancel wins
      ob = ok_q.size();
      nb = nom_q.size();
      load_bal = 1'b1; bal_in = 8'd7; start = 1'b1;
      step();
      load_bal = 1'b0; start = 1'b0;
      sel = 2'b01; confirm = 1'b1; cancel = 1'b1;
      step();
      confirm = 1'b0; cancel = 1'b0;
      chk("cc_state", state_dbg, 0);
      chk("cc_busy", busy, 0);
      repeat (10) step();
      chk("cc_ok", ok_q.size() - ob, 0);
      chk("cc_nom", nom_q.size() - nb, 0);
      chk("cc_bal", balance, 7);

      // start held through DONE restarts only via IDLE
      load_bal = 1'b1; bal_in = 8'd4; start = 1'b1;
      step();
      load_bal = 1'b0;
      sel = 2'b00; confirm = 1'b1;
      step();
      confirm = 1'b0;
      repeat (2) step();
      chk("hold_ok", ok, 1);
      chk("hold_done", state_dbg, 4);
      step();
      chk("hold_idle", state_dbg, 0);
      step();
      chk("hold_select", state_dbg, 1);
      start = 1'b0; cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("hold_cancel", state_dbg, 0);
      chk("hold_bal", balance, 3);

      // Reset in the middle of dispensing four bills
      pb = pulse_q.size();
      ob = ok_q.size();
      load_bal = 1'b1; bal_in = 8'd10; start = 1'b1;
      step();
      load_bal = 1'b0; start = 1'b0;
      sel = 2'b11; confirm = 1'b1;
      step();
      confirm = 1'b0;
      pc = cyc;
      i = 0;
      while ((pulse_q.size() - pb) < 2 && i < 50) begin
         step();
         i++;
      end
      chk("mid_two_pulses", pulse_q.size() - pb, 2);
      if (pulse_q.size() - pb >= 2) chk("mid_gap", pulse_q[pb + 1] - pulse_q[pb], GAP);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", state_dbg, 0);
      chk("mid_rst_bal", balance, 0);
      chk("mid_rst_pulse", bill_pulse, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (20) step();
      chk("mid_no_more", pulse_q.size() - pb, 2);
      chk("mid_no_ok", ok_q.size() - ob, 0);
      chk("mid_after_state", state_dbg, 0);
      chk("mid_after_bal", balance, 0);

      // Random sessions against the reference prediction
      for (int k = 0; k < 16; k++) begin
         session(int'($urandom_range(0, 12)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
      end

      chk("exclusive_pulses", excl_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion expected completion");
      $fatal(1, "watchdog");
   end

endmodule
